mem_fill: RTL and testbench

MEM_FILL -- requirements
Module: mem_fill

---
 rtl/mem_fill.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_fill.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_fill.sv
// mem_fill: writes a DEPTH-word pattern to memory, one word per cycle.
// Define MEM_FILL_VERIFY_EN to add a readback pass that compares every word
// against the pattern and raises a sticky err flag on any mismatch.
// Patterns, indexed by word i: 00 -> i, 01 -> fill_val, 10 -> DEPTH-1-i,
// 11 -> i ^ fill_val.
module mem_fill #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              rdy,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] fill_val,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wrdata,
  output logic              wren,
  input  logic [DATA_W-1:0] rddata,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_VERIFY = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_mode;
  logic [DATA_W-1:0] r_fill_val;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wrdata;
  logic              r_wren;
  logic              r_done;
  logic              r_rdy;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] w_wrdata_nxt;
  logic              w_wren_nxt;
  logic              w_done_nxt;
  logic              w_rdy_nxt;
  logic              w_accept;
  logic              w_last;
  logic [ADDR_W-1:0] w_addr_inc;

  // Pattern value for word index idx under the given mode and operand.
  function automatic logic [DATA_W-1:0] f_pattern(
    input logic [1:0]        m,
    input logic [DATA_W-1:0] fv,
    input logic [ADDR_W-1:0] idx
  );
    logic [DATA_W-1:0] v_idx;
    logic [DATA_W-1:0] v_rev;
    v_idx = DATA_W'(idx);
    v_rev = DATA_W'(LAST_ADDR - idx);
    case (m)
      2'b00:   f_pattern = v_idx;
      2'b01:   f_pattern = fv;
      2'b10:   f_pattern = v_rev;
      default: f_pattern = v_idx ^ fv;
    endcase
  endfunction

  assign w_accept   = (r_state == S_IDLE) && en;
  assign w_last     = (r_addr == LAST_ADDR);
  assign w_addr_inc = r_addr + ADDR_W'(1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a job ends on the last address of its final pass.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (en) w_state_nxt = S_FILL;
      end
      S_FILL: begin
`ifdef MEM_FILL_VERIFY_EN
        if (w_last) w_state_nxt = S_VERIFY;
`else
        if (w_last) w_state_nxt = S_IDLE;
`endif
      end
`ifdef MEM_FILL_VERIFY_EN
      S_VERIFY: begin
        if (w_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        w_state_nxt = S_IDLE;
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered memory-side outputs.
  always_comb begin
    w_addr_nxt   = '0;
    w_wrdata_nxt = '0;
    w_wren_nxt   = 1'b0;
    w_done_nxt   = 1'b0;
    w_rdy_nxt    = (w_state_nxt == S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (en) begin
          w_wren_nxt   = 1'b1;
          w_wrdata_nxt = f_pattern(mode, fill_val, '0);
        end
      end
      S_FILL: begin
        if (!w_last) begin
          w_addr_nxt   = w_addr_inc;
          w_wren_nxt   = 1'b1;
          w_wrdata_nxt = f_pattern(r_mode, r_fill_val, w_addr_inc);
        end else begin
`ifndef MEM_FILL_VERIFY_EN
          w_done_nxt = 1'b1;
`endif
        end
      end
`ifdef MEM_FILL_VERIFY_EN
      S_VERIFY: begin
        if (!w_last) begin
          w_addr_nxt = w_addr_inc;
        end else begin
          w_done_nxt = 1'b1;
        end
      end
`endif
      default: begin
        w_addr_nxt = '0;
      end
    endcase
  end

  // Output registers; reset forces the idle bus immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= '0;
      r_wrdata <= '0;
      r_wren   <= 1'b0;
      r_done   <= 1'b0;
      r_rdy    <= 1'b1;
    end else begin
      r_addr   <= w_addr_nxt;
      r_wrdata <= w_wrdata_nxt;
      r_wren   <= w_wren_nxt;
      r_done   <= w_done_nxt;
      r_rdy    <= w_rdy_nxt;
    end
  end

  // Job operands are captured once at acceptance and held for the whole job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode     <= 2'b00;
      r_fill_val <= '0;
    end else if (w_accept) begin
      r_mode     <= mode;
      r_fill_val <= fill_val;
    end
  end

  assign addr   = r_addr;
  assign wrdata = r_wrdata;
  assign wren   = r_wren;
  assign done   = r_done;
  assign rdy    = r_rdy;

`ifdef MEM_FILL_VERIFY_EN
  logic              r_cmp_vld;
  logic [ADDR_W-1:0] r_cmp_idx;
  logic              r_err;
  logic              w_mismatch;

  // Remember which address the memory is answering this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmp_vld <= 1'b0;
      r_cmp_idx <= '0;
    end else begin
      r_cmp_vld <= (r_state == S_VERIFY);
      r_cmp_idx <= r_addr;
    end
  end

  assign w_mismatch = r_cmp_vld &&
                      (rddata != f_pattern(r_mode, r_fill_val, r_cmp_idx));

  // Sticky error, cleared only by a newly accepted job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end else if (w_mismatch) begin
      r_err <= 1'b1;
    end
  end

  // The last word's compare lands in DRAIN, the same cycle as done, so it is
  // folded in combinationally to make err valid alongside done.
  assign err = r_err | w_mismatch;
`else
  logic w_unused_rddata;
  assign w_unused_rddata = ^rddata;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_fill.sv
// Scoreboard bench for mem_fill: stimulus pushes expected writes and done
// events into queues, a negedge monitor pops and compares them.
module tb_mem_fill;

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 10;
`ifdef MEM_FILL_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif
  localparam int BUSY     = VER ? 2 * DEPTH + 1 : DEPTH;
  localparam int DONE_OFF = VER ? 2 * DEPTH : DEPTH;
  localparam int TMO      = 4 * DEPTH + 20;

  typedef struct {
    int          cyc;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  typedef struct {
    int   cyc;
    logic e;
  } dn_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          rdy;
  logic [1:0]    mode;
  logic [DW-1:0] fill_val;
  logic [AW-1:0] addr;
  logic [DW-1:0] wrdata;
  logic          wren;
  logic [DW-1:0] rddata;
  logic          done;
  logic          err;

  wr_t wq[$];
  dn_t dq[$];
  int  checks   = 0;
  int  failures = 0;
  int  pcyc     = 0;
  int  busy_lo  = 0;
  int  busy_hi  = 0;
  bit  mon_en   = 1'b0;
  bit  corrupt_q = 1'b0;
  bit  last_err = 1'b0;
  logic [DW-1:0] mem [0:2**AW-1];

  mem_fill #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .mode(mode),
    .fill_val(fill_val), .addr(addr), .wrdata(wrdata), .wren(wren),
    .rddata(rddata), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) pcyc <= pcyc + 1;

  // Memory with one-cycle read latency; optionally corrupts address 7 on read.
  always @(posedge clk) begin
    if (wren === 1'b1) mem[addr] <= wrdata;
    rddata <= mem[addr] ^ ((corrupt_q && wren !== 1'b1 && addr == 8'd7) ? 8'h01 : 8'h00);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, pcyc);
    end
  endtask

  // Reference pattern for word i.
  function automatic logic [DW-1:0] exp_data(input logic [1:0] m, input logic [DW-1:0] f, input int i);
    case (m)
      2'd0:    return DW'(i);
      2'd1:    return f;
      2'd2:    return DW'(DEPTH - 1 - i);
      default: return DW'(i) ^ f;
    endcase
  endfunction

  // Monitor: compares every cycle's outputs against the scoreboard.
  always @(negedge clk) begin : mon
    wr_t w;
    dn_t d;
    if (mon_en) begin
      while (wq.size() > 0 && wq[0].cyc < pcyc) begin
        w = wq.pop_front();
        checks++; failures++;
        $display("FAIL write_missing: addr %0d due in cycle %0d, not observed", w.a, w.cyc);
      end
      if (wren === 1'b1) begin
        if (wq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_write: addr=%0h data=%0h cycle %0d", addr, wrdata, pcyc);
        end else begin
          w = wq.pop_front();
          chk("wr_addr", 32'(addr), 32'(w.a));
          chk("wr_data", 32'(wrdata), 32'(w.d));
          chk("wr_cycle", pcyc, w.cyc);
        end
      end else begin
        chk("wrdata_when_idle", 32'(wrdata), 32'd0);
      end
      chk("addr_range", 32'(addr <= AW'(DEPTH - 1)), 32'd1);
      chk("rdy", 32'(rdy), (pcyc >= busy_lo && pcyc < busy_hi) ? 32'd0 : 32'd1);
      while (dq.size() > 0 && dq[0].cyc < pcyc) begin
        d = dq.pop_front();
        checks++; failures++;
        $display("FAIL done_missing: due in cycle %0d, not observed", d.cyc);
      end
      if (done === 1'b1) begin
        if (dq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done: cycle %0d", pcyc);
        end else begin
          d = dq.pop_front();
          chk("done_cycle", pcyc, d.cyc);
          chk("err_at_done", 32'(err), 32'(d.e));
        end
      end
`ifndef MEM_FILL_VERIFY_EN
      chk("err_tied_low", 32'(err), 32'd0);
`endif
    end
  end

  // Wait for rdy, present one job, and record its expected responses.
  task automatic accept_job(input logic [1:0] m, input logic [DW-1:0] f, input bit corrupt, output int acc);
    int n = 0;
    while (rdy !== 1'b1 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    chk("rdy_wait", 32'(rdy), 32'd1);
    chk("err_sticky_before_accept", 32'(err), 32'(last_err));
    mode = m; fill_val = f; en = 1'b1; corrupt_q = corrupt;
    @(posedge clk); #1;
    acc = pcyc;
    chk("err_cleared_on_accept", 32'(err), 32'd0);
    busy_lo = acc;
    busy_hi = acc + BUSY;
    for (int i = 0; i < int'(DEPTH); i++)
      wq.push_back('{cyc: acc + i, a: AW'(i), d: exp_data(m, f, i)});
    dq.push_back('{cyc: acc + DONE_OFF, e: VER && corrupt});
    last_err = VER && corrupt;
  endtask

  // One full job; inputs churn and stray en pulses hit while busy.
  task automatic run_job(input logic [1:0] m, input logic [DW-1:0] f, input bit hold, input bit corrupt);
    int acc;
    accept_job(m, f, corrupt, acc);
    for (int k = 0; k < BUSY - 1; k++) begin
      @(negedge clk);
      mode = 2'($urandom); fill_val = DW'($urandom);
      en = hold ? 1'b1 : 1'(($urandom % 3) == 0);
    end
    @(negedge clk);
    mode = 2'($urandom); fill_val = DW'($urandom);
    en = hold;
  endtask

  // Abort a job at write index 4 with an asynchronous reset, then restart.
  task automatic reset_mid_job();
    int acc;
    accept_job(2'd1, DW'($urandom), 1'b0, acc);
    en = 1'b0;
    while (pcyc < acc + 4) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("abort_wren", 32'(wren), 32'd0);
    chk("abort_addr", 32'(addr), 32'd0);
    chk("abort_rdy", 32'(rdy), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    wq.delete(); dq.delete();
    busy_lo = 0; busy_hi = 0; last_err = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_job(2'd0, DW'($urandom), 1'b0, 1'b0);
  endtask

  initial begin : watchdog
    #300000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : stim
    int n;
    rst_n = 1'b1; en = 1'b0; mode = 2'd0; fill_val = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_rdy", 32'(rdy), 32'd1);
    chk("reset_wren", 32'(wren), 32'd0);
    chk("reset_addr", 32'(addr), 32'd0);
    chk("reset_wrdata", 32'(wrdata), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    // en on the very first edge after release
    run_job(2'd0, DW'($urandom), 1'b0, 1'b0);
    run_job(2'd2, DW'($urandom), 1'b0, 1'b0);
    run_job(2'd3, 8'hA5, 1'b0, 1'b0);
    run_job(2'd1, 8'h3C, 1'b0, 1'b0);
    repeat (6) run_job(2'($urandom), DW'($urandom), 1'b0, 1'b0);
    run_job(2'($urandom), DW'($urandom), 1'b0, 1'b1);
    run_job(2'($urandom), DW'($urandom), 1'b0, 1'b0);
    reset_mid_job();
    run_job(2'($urandom), DW'($urandom), 1'b1, 1'b0);
    run_job(2'($urandom), DW'($urandom), 1'b1, 1'b0);
    run_job(2'($urandom), DW'($urandom), 1'b0, 1'b0);
    n = 0;
    while ((wq.size() != 0 || dq.size() != 0) && n < TMO) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("scoreboard_empty", 32'(wq.size() + dq.size()), 32'd0);
    chk("final_rdy", 32'(rdy), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
